uart_instr_sender: RTL and testbench
====================================

UART_INSTR_SENDER -- requirements
Module: uart_instr_sender

Interface
REQ-001 Parameter BPS, default 217, sets UART clock cycles per bit; it is passed unchanged to uart_tx and uart_rx.
REQ-002 Parameter ADDR_W, default 10, sets the word-RAM address width.
REQ-003 Parameter ACK_TO, default BPS*400, sets the acknowledge timeout in clock cycles.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle request to send a burst; sampled only in IDLE.
REQ-007 num_words  in  ADDR_W+1  burst length in 32-bit words; captured with start.
REQ-008 base_addr  in  ADDR_W  first RAM address; captured with start.
REQ-009 rd_en  out  1  RAM read strobe.
REQ-010 rd_addr  out  ADDR_W  RAM read address.
REQ-011 rd_data  in  32  RAM read data, valid exactly 1 cycle after rd_en.
REQ-012 tx  out  1  UART serial out, idle high.
REQ-013 rx  in  1  UART serial in, carries the 1-byte acknowledge.
REQ-014 busy  out  1  high from the cycle after an accepted start until done.
REQ-015 done  out  1  one-cycle pulse at burst end.
REQ-016 ack_ok, err_nack, err_timeout  out  1 each  burst status, valid with done and held until the next accepted start.

Function
REQ-017 States: IDLE, READ, LOAD, SEND, NEXT, DRAIN, WAIT_ACK, FIN.
REQ-018 IDLE: start=1 and num_words>0 -> READ; start=1 and num_words=0 -> FIN with ack_ok=1; no bytes are sent.
REQ-019 start while busy=1 is ignored and has no side effects.
REQ-020 READ: rd_en=1 for exactly one cycle with rd_addr=base_addr+word_index (modulo 2^ADDR_W, wrapping) -> LOAD.
REQ-021 LOAD: capture rd_data into the 32-bit shift register; byte_cnt=0 -> SEND.
REQ-022 SEND: a one-cycle byte strobe to uart_tx is issued only when tx_rdy=1 and no strobe was issued in the previous cycle; the strobe carries byte [31:24], then [23:16], [15:8], [7:0] (MSB first).
REQ-023 After the 4th strobe -> NEXT; word_index increments; if word_index=num_words -> DRAIN, else -> READ.
REQ-024 DRAIN: wait until tx_rdy=1 (last stop bit complete) -> WAIT_ACK; the timeout counter is cleared on entry.
REQ-025 WAIT_ACK: an rx byte of 8'hFF sets ack_ok=1; any other byte sets err_nack=1; counter reaching ACK_TO-1 first sets err_timeout=1; each of these -> FIN.
REQ-026 An rx byte and a timeout in the same cycle: the byte wins.
REQ-027 rx bytes received outside WAIT_ACK are discarded.
REQ-028 FIN: done=1 for one cycle, busy=0 -> IDLE; exactly one status bit is high.
REQ-029 The timeout counter is at least 20 bits wide and saturates at ACK_TO-1.

Reset
REQ-030 rst low asynchronously forces state IDLE with busy=0, done=0, rd_en=0, rd_addr=0, all status bits 0 and tx=1.
REQ-031 Reset mid-burst abandons the frame; after release the block accepts a new start and the line stays idle.

Structure
REQ-032 State encodings and the ACK_BYTE constant (8'hFF) reside in a shared header included by all UART loader blocks.
REQ-033 The existing uart_tx and uart_rx are instantiated, not re-implemented; their active-high rst is driven by the inverse of rst.
REQ-034 There is no other sub-module.

Verification
REQ-035 BPS=8, num_words=1, base_addr=5, RAM[5]=32'h12345678, loopback responder sends 8'hFF -> tx bytes 12,34,56,78 in order; done with ack_ok=1.
REQ-036 num_words=3, base_addr=2^ADDR_W-1 -> reads addresses 1023, 0, 1 (wrap); 12 bytes are sent; done.
REQ-037 Responder replies 8'h00 -> done with err_nack=1, ack_ok=0.
REQ-038 No reply -> done exactly ACK_TO cycles after WAIT_ACK entry, with err_timeout=1.
REQ-039 num_words=0 -> done 2 cycles after start, ack_ok=1, tx stays 1; a start pulse during the busy period is ignored.
REQ-040 rst asserted during the 2nd byte -> tx=1 immediately, busy=0; a subsequent burst completes correctly.

Source files
------------

// File: rtl/uart_instr_sender_pkg.sv
// Shared definitions for the UART loader blocks: sender state encoding,
// the acknowledge byte value and a small width helper for bit-period counters.
package uart_instr_sender_pkg;

  // Sender FSM states
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_LOAD     = 3'd2,
    S_SEND     = 3'd3,
    S_NEXT     = 3'd4,
    S_DRAIN    = 3'd5,
    S_WAIT_ACK = 3'd6,
    S_FIN      = 3'd7
  } state_t;

  // Byte the far end returns to accept a burst
  localparam logic [7:0] ACK_BYTE = 8'hFF;

  // Width of a counter that must hold values 0..n-1 (never zero bits wide)
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_instr_sender_uart.sv
// 8N1 UART transmitter and receiver used by the loader blocks.
// Handshake: uart_tx accepts a byte on any cycle where tx_start=1 and tx_rdy=1;
// tx_rdy drops in the very next cycle and rises again once the stop bit has
// been on the line for a full bit period. uart_rx emits rx_valid for exactly
// one cycle with rx_data when a frame with a valid stop bit has been received.

module uart_tx
  import uart_instr_sender_pkg::*;
#(
  parameter int BPS = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_rdy
);

  localparam int            BW        = cnt_w(BPS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BPS - 1);

  logic          active;
  logic [9:0]    frame;
  logic [3:0]    bit_cnt;
  logic [BW-1:0] baud_cnt;

  // Shift out start bit, 8 data bits LSB first, stop bit; frame refills with 1s
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      frame    <= '1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
    end else if (!active) begin
      if (tx_start) begin
        active   <= 1'b1;
        frame    <= {1'b1, tx_data, 1'b0};
        bit_cnt  <= '0;
        baud_cnt <= '0;
      end
    end else if (baud_cnt == BAUD_LAST) begin
      baud_cnt <= '0;
      frame    <= {1'b1, frame[9:1]};
      if (bit_cnt == 4'd9) begin
        active <= 1'b0;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
      end
    end else begin
      baud_cnt <= baud_cnt + BW'(1);
    end
  end

  assign tx     = frame[0];
  assign tx_rdy = ~active;

endmodule

module uart_rx
  import uart_instr_sender_pkg::*;
#(
  parameter int BPS = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data
);

  localparam int            BW        = cnt_w(BPS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BPS - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BPS / 2 - 1);

  logic          rx_s1;
  logic          rx_s2;
  logic          rxing;
  logic [3:0]    bit_cnt;
  logic [BW-1:0] baud_cnt;
  logic [7:0]    shreg;

  // Two-flop synchroniser for the asynchronous serial input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  // Find start bit, sample mid-bit, deliver the byte if the stop bit is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxing    <= 1'b0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      shreg    <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (!rxing) begin
        if (!rx_s2) begin
          rxing    <= 1'b1;
          bit_cnt  <= '0;
          baud_cnt <= '0;
        end
      end else if (baud_cnt == ((bit_cnt == 4'd0) ? BAUD_HALF : BAUD_LAST)) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd0) begin
          // a start bit that is high again at mid-bit was a glitch
          if (rx_s2) begin
            rxing <= 1'b0;
          end else begin
            bit_cnt <= 4'd1;
          end
        end else if (bit_cnt <= 4'd8) begin
          shreg   <= {rx_s2, shreg[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else begin
          rxing <= 1'b0;
          if (rx_s2) begin
            rx_valid <= 1'b1;
            rx_data  <= shreg;
          end
        end
      end else begin
        baud_cnt <= baud_cnt + BW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_instr_sender.sv
// uart_instr_sender: reads a burst of 32-bit words from a word RAM, sends each
// word over UART most-significant byte first, then waits for a one-byte
// acknowledge on rx (ACK_BYTE = accepted, anything else = rejected, silence =
// timeout). A start is registered for one cycle before it is acted on, so busy
// is high in the cycle after an accepted start and done follows in the FIN
// cycle, when busy is already low.
module uart_instr_sender
  import uart_instr_sender_pkg::*;
#(
  parameter int BPS    = 217,
  parameter int ADDR_W = 10,
  parameter int ACK_TO = BPS * 400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              tx,
  input  logic              rx,
  output logic              busy,
  output logic              done,
  output logic              ack_ok,
  output logic              err_nack,
  output logic              err_timeout,
  output state_t            dbg_state
);

  localparam logic [31:0]   ACK_LAST = 32'(ACK_TO - 1);
  localparam logic [ADDR_W:0] ONE_W  = (ADDR_W + 1)'(1);

  state_t              state;
  state_t              next_state;

  logic                uart_rst;
  logic                tx_start;
  logic                tx_rdy;
  logic                rx_valid;
  logic [7:0]          rx_data;

  logic                pend;
  logic [ADDR_W:0]     nw_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     word_idx;
  logic [ADDR_W:0]     word_idx_inc;
  logic [31:0]         shreg;
  logic [1:0]          byte_cnt;
  logic                strobe_q;
  logic [31:0]         ack_cnt;

  logic                accept;
  logic                fourth_strobe;
  logic                got_byte;
  logic                timed_out;

  assign uart_rst      = ~rst;
  assign word_idx_inc  = word_idx + ONE_W;
  assign accept        = (state == S_IDLE) && !pend && start;
  assign fourth_strobe = tx_start && (byte_cnt == 2'd3);
  assign got_byte      = (state == S_WAIT_ACK) && rx_valid;
  assign timed_out     = (state == S_WAIT_ACK) && (ack_cnt == ACK_LAST);
  assign dbg_state     = state;

  uart_tx #(.BPS(BPS)) u_tx (
    .clk      (clk),
    .rst      (uart_rst),
    .tx_start (tx_start),
    .tx_data  (shreg[31:24]),
    .tx       (tx),
    .tx_rdy   (tx_rdy)
  );

  uart_rx #(.BPS(BPS)) u_rx (
    .clk      (clk),
    .rst      (uart_rst),
    .rx       (rx),
    .rx_valid (rx_valid),
    .rx_data  (rx_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (pend) begin
          next_state = (nw_q == '0) ? S_FIN : S_READ;
        end
      end
      S_READ:  next_state = S_LOAD;
      S_LOAD:  next_state = S_SEND;
      S_SEND: begin
        if (fourth_strobe) begin
          next_state = S_NEXT;
        end
      end
      S_NEXT: begin
        next_state = (word_idx_inc == nw_q) ? S_DRAIN : S_READ;
      end
      S_DRAIN: begin
        if (tx_rdy) begin
          next_state = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (got_byte || timed_out) begin
          next_state = S_FIN;
        end
      end
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // FSM outputs: RAM strobe/address, byte strobe, busy and done
  always_comb begin
    rd_en    = 1'b0;
    rd_addr  = '0;
    tx_start = 1'b0;
    done     = 1'b0;
    busy     = pend;
    unique case (state)
      S_IDLE: ;
      S_READ: begin
        rd_en   = 1'b1;
        rd_addr = base_q + word_idx[ADDR_W-1:0];
        busy    = 1'b1;
      end
      S_SEND: begin
        // never strobe on back-to-back cycles, even if ready is still high
        tx_start = tx_rdy && !strobe_q;
        busy     = 1'b1;
      end
      S_FIN:   done = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  // Burst bookkeeping, byte serialiser, acknowledge timer and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend        <= 1'b0;
      nw_q        <= '0;
      base_q      <= '0;
      word_idx    <= '0;
      shreg       <= '0;
      byte_cnt    <= '0;
      strobe_q    <= 1'b0;
      ack_cnt     <= '0;
      ack_ok      <= 1'b0;
      err_nack    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      strobe_q <= tx_start;

      if (accept) begin
        pend        <= 1'b1;
        nw_q        <= num_words;
        base_q      <= base_addr;
        ack_ok      <= 1'b0;
        err_nack    <= 1'b0;
        err_timeout <= 1'b0;
      end

      if ((state == S_IDLE) && pend) begin
        pend     <= 1'b0;
        word_idx <= '0;
        // an empty burst is trivially acknowledged
        if (nw_q == '0) begin
          ack_ok <= 1'b1;
        end
      end

      if (state == S_LOAD) begin
        shreg    <= rd_data;
        byte_cnt <= '0;
      end

      if (tx_start) begin
        shreg    <= {shreg[23:0], 8'h00};
        byte_cnt <= byte_cnt + 2'd1;
      end

      if (state == S_NEXT) begin
        word_idx <= word_idx_inc;
      end

      if (state == S_DRAIN) begin
        ack_cnt <= '0;
      end else if ((state == S_WAIT_ACK) && (ack_cnt != ACK_LAST)) begin
        ack_cnt <= ack_cnt + 32'd1;
      end

      // a byte arriving in the timeout cycle takes precedence
      if (got_byte) begin
        if (rx_data == ACK_BYTE) begin
          ack_ok <= 1'b1;
        end else begin
          err_nack <= 1'b1;
        end
      end else if (timed_out) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_instr_sender.sv
// Bench for uart_instr_sender: RAM model, UART line decoder and responder,
// expected queues for bytes, read addresses and burst status.
module tb_uart_instr_sender;
  import uart_instr_sender_pkg::*;

  localparam int BPS    = 8;
  localparam int ADDR_W = 10;
  localparam int ACK_TO = BPS * 400;

  localparam logic [2:0] ST_ACK  = 3'b100;
  localparam logic [2:0] ST_NACK = 3'b010;
  localparam logic [2:0] ST_TO   = 3'b001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic              start = 1'b0;
  logic [ADDR_W:0]   num_words = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data = '0;
  logic              tx;
  logic              rx = 1'b1;
  logic              busy, done, ack_ok, err_nack, err_timeout;
  state_t            dbg_state;

  uart_instr_sender #(.BPS(BPS), .ADDR_W(ADDR_W), .ACK_TO(ACK_TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_words   (num_words),
    .base_addr   (base_addr),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .tx          (tx),
    .rx          (rx),
    .busy        (busy),
    .done        (done),
    .ack_ok      (ack_ok),
    .err_nack    (err_nack),
    .err_timeout (err_timeout),
    .dbg_state   (dbg_state)
  );

  // ---------------- RAM model: data one cycle after the read strobe ----------------
  logic [31:0] ram [1024];
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         addr_q[$];
  logic [2:0] exp_status = ST_ACK;
  int         done_cnt = 0;
  int         last_done_cyc = 0;
  int         bytes_seen = 0;
  logic [7:0] byte_log [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- compare process ----------------
  logic       dec_active = 1'b0;
  int         dec_t = 0;
  int         dec_idx = 0;
  logic [7:0] dec_byte = '0;
  logic [7:0] exp_b;
  int         exp_a;

  always @(negedge clk) begin
    check("status_onehot0", ($countones({ack_ok, err_nack, err_timeout}) <= 1) ? 32'd1 : 32'd0, 32'd1);

    if (done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
      check("done_status", 32'({ack_ok, err_nack, err_timeout}), 32'(exp_status));
      check("done_busy_low", 32'(busy), 32'd0);
    end

    if (rd_en === 1'b1) begin
      if (addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got read of %0d, expected no read", rd_addr);
      end else begin
        exp_a = addr_q.pop_front();
        check("rd_addr", 32'(rd_addr), 32'(exp_a));
      end
    end

    // UART line decoder: sample each bit in the middle of its period
    if (!rst) begin
      dec_active = 1'b0;
    end else if (!dec_active) begin
      if (tx === 1'b0) begin
        dec_active = 1'b1;
        dec_t      = 0;
      end
    end else begin
      dec_t++;
      if (dec_t % BPS == BPS / 2) begin
        dec_idx = dec_t / BPS;
        if (dec_idx >= 1 && dec_idx <= 8) begin
          dec_byte[dec_idx-1] = tx;
        end else if (dec_idx == 9) begin
          check("tx_stop_bit", 32'(tx), 32'd1);
          if (bytes_seen < 256) byte_log[bytes_seen] = dec_byte;
          bytes_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected_byte: got %02h, expected no byte", dec_byte);
          end else begin
            exp_b = exp_q.pop_front();
            check("tx_byte", 32'(dec_byte), 32'(exp_b));
          end
          dec_active = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      tick(BPS);
    end
  endtask

  // queue the expected reads/bytes of a burst from the RAM contents
  task automatic expect_burst(input int nw, input int base);
    int a;
    for (int i = 0; i < nw; i++) begin
      a = (base + i) % 1024;
      addr_q.push_back(a);
      exp_q.push_back(ram[a][31:24]);
      exp_q.push_back(ram[a][23:16]);
      exp_q.push_back(ram[a][15:8]);
      exp_q.push_back(ram[a][7:0]);
    end
  endtask

  task automatic pulse_start(input int nw, input int base);
    num_words = (ADDR_W + 1)'(nw);
    base_addr = ADDR_W'(base);
    start     = 1'b1;
    tick(1);
    start     = 1'b0;
  endtask

  // reply: 0 -> ACK_BYTE, 1 -> 8'h00, 2 -> silence (timeout)
  task automatic run_burst(input string name, input int nw, input int base, input int reply,
                           input logic [2:0] st);
    int d0, b_target, t, e;
    exp_status = st;
    expect_burst(nw, base);
    d0       = done_cnt;
    b_target = bytes_seen + 4 * nw;
    pulse_start(nw, base);
    t = 0;
    while (bytes_seen < b_target && t < nw * 4 * 12 * BPS + 200) begin
      tick(1);
      t++;
    end
    check({name, "_bytes_sent"}, 32'(bytes_seen), 32'(b_target));
    if (reply == 2) begin
      t = 0;
      while (dbg_state != S_WAIT_ACK && t < 20 * BPS) begin
        tick(1);
        t++;
      end
      e = cyc;
      check({name, "_wait_ack_reached"}, (dbg_state == S_WAIT_ACK) ? 32'd1 : 32'd0, 32'd1);
    end else begin
      e = 0;
      tick(2 * BPS);
      send_rx_byte((reply == 0) ? 8'hFF : 8'h00);
    end
    t = 0;
    while (done_cnt == d0 && t < ACK_TO + 40 * BPS) begin
      tick(1);
      t++;
    end
    check({name, "_done_seen"}, 32'(done_cnt), 32'(d0 + 1));
    if (reply == 2) check({name, "_timeout_latency"}, 32'(last_done_cyc - e), 32'(ACK_TO));
    check({name, "_addr_q_empty"}, 32'(addr_q.size()), 32'd0);
    check({name, "_byte_q_empty"}, 32'(exp_q.size()), 32'd0);
    tick(3);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int b0, c, d0, t;
    for (int i = 0; i < 1024; i++) ram[i] = (32'(i) * 32'h01010101) ^ 32'h5A000000;
    ram[5]    = 32'h12345678;
    ram[1023] = 32'hA1B2C3D4;
    ram[0]    = 32'h00FF7E81;
    ram[1]    = 32'hCAFEF00D;

    // reset values
    rst = 1'b0;
    tick(4);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_status", 32'({ack_ok, err_nack, err_timeout}), 32'd0);
    check("rst_tx", 32'(tx), 32'd1);
    rst = 1'b1;
    tick(4);

    // single word, acknowledged
    b0 = bytes_seen;
    run_burst("ack1", 1, 5, 0, ST_ACK);
    check("ack1_first_byte", 32'(byte_log[b0]), 32'h12);
    check("ack1_last_byte", 32'(byte_log[b0+3]), 32'h78);
    check("ack1_ack_held", 32'({ack_ok, err_nack, err_timeout}), 32'(ST_ACK));

    // a byte on rx while idle must not leak into the next burst's status
    send_rx_byte(8'h00);
    tick(2 * BPS);

    // three words wrapping around the top of the address space
    b0 = bytes_seen;
    run_burst("wrap", 3, 1023, 0, ST_ACK);
    check("wrap_byte_count", 32'(bytes_seen - b0), 32'd12);
    check("wrap_first_byte", 32'(byte_log[b0]), 32'hA1);
    check("wrap_mid_byte", 32'(byte_log[b0+5]), 32'hFF);
    check("wrap_last_byte", 32'(byte_log[b0+11]), 32'h0D);

    // negative acknowledge
    run_burst("nack", 2, 40, 1, ST_NACK);
    check("nack_status_held", 32'({ack_ok, err_nack, err_timeout}), 32'(ST_NACK));

    // silence on rx -> timeout
    run_burst("tmo", 1, 7, 2, ST_TO);
    check("tmo_status_held", 32'({ack_ok, err_nack, err_timeout}), 32'(ST_TO));

    // empty burst; a second start while busy is ignored
    exp_status = ST_ACK;
    d0 = done_cnt;
    num_words = '0;
    base_addr = ADDR_W'(3);
    start = 1'b1;
    c = cyc;
    tick(1);
    check("zero_busy", 32'(busy), 32'd1);
    num_words = (ADDR_W + 1)'(1);
    tick(1);
    start = 1'b0;
    check("zero_done_pulse", 32'(done), 32'd1);
    check("zero_tx_idle", 32'(tx), 32'd1);
    tick(12 * BPS);
    check("zero_done_count", 32'(done_cnt), 32'(d0 + 1));
    check("zero_done_latency", 32'(last_done_cyc - c), 32'd2);
    check("zero_busy_after", 32'(busy), 32'd0);
    check("zero_ack_ok", 32'(ack_ok), 32'd1);

    // reset during the second byte abandons the frame
    exp_status = ST_ACK;
    expect_burst(2, 100);
    b0 = bytes_seen;
    pulse_start(2, 100);
    t = 0;
    while (!(bytes_seen == b0 + 1 && dec_active) && t < 40 * BPS) begin
      tick(1);
      t++;
    end
    check("rstmid_in_second_byte", (bytes_seen == b0 + 1 && dec_active) ? 32'd1 : 32'd0, 32'd1);
    tick(2 * BPS);
    rst = 1'b0;
    #1;
    check("rstmid_tx_idle", 32'(tx), 32'd1);
    check("rstmid_busy", 32'(busy), 32'd0);
    exp_q.delete();
    addr_q.delete();
    tick(3);
    rst = 1'b1;
    tick(12 * BPS);
    check("rstmid_quiet_after", 32'(bytes_seen), 32'(b0 + 1));
    check("rstmid_tx_after", 32'(tx), 32'd1);
    run_burst("after_rst", 2, 100, 0, ST_ACK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
